sobolrng_seq_ctrl: RTL and testbench

Sequencer that drives sobolrng_core. It runs a Sobol index counter over a programmable run length and emits the one-hot of the lowest zero bit of each index, which is the direction-vector select in Gray-code order. It also generates the core's iEn and iClr strobes and reports run status (busy, count, done pulse). It sits directly upstream of sobolrng_core, and its oOneHot/oEn/oClr connect straight to the core's iOneHot/iEn/iClr.

---
 rtl/sobolrng_pkg.sv | 17 +
 rtl/sobolrng_lzd.sv | 11 +
 rtl/sobolrng_seq_ctrl.sv | 82 ++++++++
 tb/tb_sobolrng_seq_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sobolrng_pkg.sv
// Shared types and helpers for the Sobol RNG stages.
package sobolrng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // One-hot of the lowest zero bit; callers truncate to their own width,
  // which maps an all-ones input to zero.
  function automatic logic [31:0] lowest_zero(input logic [31:0] x);
    return ~x & (x + 32'd1);
  endfunction

endpackage

// File: rtl/sobolrng_lzd.sv
// Lowest-zero detector: one-hot of the lowest 0 bit of x_i, zero when x_i is all ones.
module sobolrng_lzd #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic [BITWIDTH-1:0] x_i,
  output logic [BITWIDTH-1:0] y_o
);

  assign y_o = ~x_i & (x_i + BITWIDTH'(1));

endmodule

// File: rtl/sobolrng_seq_ctrl.sv
// Sobol index sequencer: walks the index over a programmable run length and drives
// the core's direction-vector select, advance and clear strobes.
module sobolrng_seq_ctrl
  import sobolrng_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iClr,
  input  logic                iEn,
  input  logic [BITWIDTH-1:0] iLen,
  output logic [BITWIDTH-1:0] oOneHot,
  output logic                oEn,
  output logic                oClr,
  output logic                oBusy,
  output logic                oDone,
  output logic [BITWIDTH-1:0] oCnt
);

  localparam int unsigned CW = BITWIDTH + 1;

  seq_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       len_q, len_d;
  logic [BITWIDTH-1:0] lzd_w;

  sobolrng_lzd #(.BITWIDTH(BITWIDTH)) u_lzd (
    .x_i(cnt_q[BITWIDTH-1:0]),
    .y_o(lzd_w)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (iClr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            // A zero length encodes a full 2^BITWIDTH period.
            len_d   = (iLen == '0) ? {1'b1, {BITWIDTH{1'b0}}} : {1'b0, iLen};
            cnt_d   = '0;
            state_d = CLR;
          end
        end
        CLR: state_d = RUN;
        RUN: begin
          if (iEn) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == len_q - CW'(1)) state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
      endcase
    end
  end

  assign oClr    = (state_q == CLR);
  assign oEn     = (state_q == RUN) & iEn;
  assign oOneHot = (state_q == RUN) ? lzd_w : '0;
  assign oBusy   = (state_q != IDLE);
  assign oDone   = (state_q == DONE);
  assign oCnt    = cnt_q[BITWIDTH-1:0];

endmodule

// File: tb/tb_sobolrng_seq_ctrl.sv
// Self-checking bench for sobolrng_seq_ctrl with BITWIDTH=4.
module tb_sobolrng_seq_ctrl;
  localparam int BW = 4;

  logic          clk = 1'b0, rstn = 1'b1, start = 1'b0, clr = 1'b0, en = 1'b0;
  logic [BW-1:0] len = '0;
  logic [BW-1:0] onehot, cnt;
  logic          oen, oclr, busy, done;

  always #5 clk = ~clk;

  sobolrng_seq_ctrl #(.BITWIDTH(BW)) dut (
    .iClk(clk), .iRstN(rstn), .iStart(start), .iClr(clr), .iEn(en), .iLen(len),
    .oOneHot(onehot), .oEn(oen), .oClr(oclr), .oBusy(busy), .oDone(done), .oCnt(cnt)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a pending clear cycle, samples still to emit, index, and a done flag.
  bit m_clrcyc, m_done;
  int m_rem, m_idx;
  bit m_run;

  function automatic int lowzero(input int v);
    for (int b = 0; b < BW; b++)
      if (((v >> b) & 1) == 0) return 1 << b;
    return 0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn || (rstn && clr)) begin
      m_clrcyc <= 1'b0; m_done <= 1'b0; m_rem <= 0; m_idx <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_clrcyc) begin
      m_clrcyc <= 1'b0;
    end else if (m_rem > 0) begin
      if (en) begin
        m_idx <= m_idx + 1;
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_done <= 1'b1;
      end
    end else if (start) begin
      m_clrcyc <= 1'b1;
      m_rem    <= (len == '0) ? (1 << BW) : int'(len);
      m_idx    <= 0;
    end
  end

  always @(negedge clk) begin
    m_run = (m_rem > 0) && !m_clrcyc;
    chk("oClr",    int'(oclr),   int'(m_clrcyc));
    chk("oEn",     int'(oen),    int'(m_run && en));
    chk("oOneHot", int'(onehot), m_run ? lowzero(m_idx % (1 << BW)) : 0);
    chk("oBusy",   int'(busy),   int'(m_clrcyc || m_rem > 0 || m_done));
    chk("oDone",   int'(done),   int'(m_done));
    chk("oCnt",    int'(cnt),    m_idx % (1 << BW));
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  bit          en_pat[$];
  int          x_acc;
  logic [15:0] seen;
  int          last_oh;

  // Samples from the current negedge onward until oDone, counting oEn pulses and
  // accumulating the value a downstream core would produce.
  task automatic run(input int maxc, output int pulses, output bit got);
    pulses = 0; got = 1'b0; x_acc = 0; seen = 16'h0001; last_oh = -1;
    for (int c = 0; c < maxc; c++) begin
      smp();
      if (oen) begin
        pulses++;
        last_oh = int'(onehot);
        for (int b = 0; b < BW; b++)
          if (onehot[b]) x_acc = x_acc ^ (1 << (BW - 1 - b));
        if (pulses < 16) seen = seen | (16'(1) << x_acc);
      end
      if (done) begin got = 1'b1; break; end
      tick();
      if (en_pat.size() > 0) en = en_pat[c % en_pat.size()];
    end
    chk("run_reaches_done", int'(got), 1);
  endtask

  int seq[8] = '{1, 2, 1, 4, 1, 2, 1, 8};
  int p, p2;
  bit g;

  initial begin
    #1 rstn = 1'b0;
    #12;
    chk("rst_busy", int'(busy), 0); chk("rst_onehot", int'(onehot), 0);
    chk("rst_cnt", int'(cnt), 0);   chk("rst_done", int'(done), 0);
    rstn = 1'b1;
    tick();

    // Basic run, length 8
    len = 4'd8; en = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    smp(); chk("basic_clr_t1", int'(oclr), 1);
    for (int i = 0; i < 8; i++) begin
      tick(); smp();
      chk("basic_onehot_seq", int'(onehot), seq[i]);
      chk("basic_en_seq", int'(oen), 1);
    end
    tick(); smp(); chk("basic_done_t10", int'(done), 1); chk("basic_cnt_final", int'(cnt), 8);
    tick(); smp(); chk("basic_busy_t11", int'(busy), 0);

    // Full period
    tick(); len = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    run(40, p, g);
    chk("full_pulses", p, 16);
    chk("full_last_onehot", last_oh, 0);
    chk("full_sobol_perm", int'(seen), 16'hFFFF);
    chk("full_cnt_wrap", int'(cnt), 0);

    // Stall pattern
    tick(); tick(); len = 4'd4; start = 1'b1;
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    tick(); start = 1'b0;
    run(40, p, g);
    chk("stall_pulses", p, 4);
    en_pat.delete(); en = 1'b1;

    // Abort at cnt=3 with iEn low in the clear cycle
    tick(); tick(); len = 4'd8; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (oen && cnt == 4'd2) break;
      tick();
    end
    tick(); chk("abort_cnt_before", int'(cnt), 3);
    clr = 1'b1; en = 1'b0;
    tick(); clr = 1'b0; en = 1'b1;
    smp(); chk("abort_busy", int'(busy), 0); chk("abort_cnt", int'(cnt), 0);
    chk("abort_no_done", int'(done), 0);
    repeat (3) tick();

    // iClr with iStart in IDLE
    len = 4'd5; start = 1'b1; clr = 1'b1;
    tick(); start = 1'b0; clr = 1'b0;
    smp(); chk("clrstart_busy", int'(busy), 0); chk("clrstart_clr", int'(oclr), 0);

    // iStart during RUN ignored
    tick(); len = 4'd5; start = 1'b1;
    tick(); start = 1'b0;
    p2 = 0;
    smp(); tick();
    smp(); if (oen) p2++;
    tick(); start = 1'b1; len = 4'd2;
    smp(); if (oen) p2++;
    tick(); start = 1'b0;
    run(30, p, g);
    chk("restart_ignored_pulses", p + p2, 5);

    // Back-to-back start right after oDone
    tick(); len = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    smp(); chk("b2b_clr_first", int'(oclr), 1); chk("b2b_no_en_in_clr", int'(oen), 0);
    run(20, p, g);
    chk("b2b_pulses", p, 3);

    // Asynchronous reset mid-run
    tick(); tick(); len = 4'd8; start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0); chk("arst_en", int'(oen), 0);
    chk("arst_onehot", int'(onehot), 0); chk("arst_cnt", int'(cnt), 0);
    chk("arst_done", int'(done), 0);
    tick(); rstn = 1'b1;
    repeat (5) begin
      smp(); chk("post_rst_busy", int'(busy), 0); chk("post_rst_onehot", int'(onehot), 0);
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
